// File: rtl/bus_arbiter_rr.sv
// ============================================================================
// bus_arbiter_rr
//
// Round-robin arbiter and sequencer for the shared LC-3 datapath bus. Four
// gate sources (0 = PC, 1 = MDR, 2 = ALU, 3 = MARMUX) request the bus. The
// block registers a one-hot grant and the matching 4:1 mux select. One cycle
// later it registers the selected word onto Dout, qualified by bus_valid.
//
// Parameters:
//   WIDTH     data width of each source word and of Dout
//   MAX_HOLD  maximum consecutive grant cycles per tenure (>= 1). This
//             parameter is used only when ARB_TIMEOUT_EN is defined.
//
// Configuration macro:
//   ARB_TIMEOUT_EN  When this macro is defined, a tenure is limited to
//                   MAX_HOLD cycles. After the limit, the grant is handed to
//                   the next requester. When the macro is undefined, the
//                   owner keeps the bus for as long as it requests it.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   req[3:0]   in   level-sensitive request, bit i = source i
//   Din0..3    in   source data words
//   gnt[3:0]   out  registered one-hot grant, all-zero when idle
//   sel[1:0]   out  registered mux select (encoded gnt index). It holds its
//                   value while idle.
//   Dout       out  registered bus word, zero when bus_valid is low
//   bus_valid  out  Dout carries the word of the source granted last cycle
// ============================================================================
module bus_arbiter_rr #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] Din0,
    input  logic [WIDTH-1:0] Din1,
    input  logic [WIDTH-1:0] Din2,
    input  logic [WIDTH-1:0] Din3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] Dout,
    output logic             bus_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [1:0]       last, last_n;     // most recently granted index
    logic [1:0]       win;              // round-robin winner, searched from last
    logic             keep;             // current owner holds through this edge
    logic             expired;          // current tenure has used all its cycles
    logic [3:0]       gnt_n;
    logic [1:0]       sel_n;
    logic [WIDTH-1:0] din_sel;
    logic [WIDTH-1:0] dout_n;
    logic             valid_n;

    // The scan visits base+1 .. base+4. The last candidate is base itself, so
    // the previous owner is the lowest-priority candidate. A lone requester
    // is therefore re-granted to itself.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam int             CW        = $clog2(MAX_HOLD) + 1;
    localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

    // This count starts at 0 on the first grant cycle. Expiry at MAX_HOLD-1
    // therefore releases the grant after exactly MAX_HOLD cycles of gnt.
    logic [CW-1:0] hold_cnt, hold_cnt_n;

    assign expired = (hold_cnt == HOLD_LAST);

    // The counter saturates instead of wrapping. Any edge that is not a hold
    // (a new grant, a hand-off or idle) clears it.
    always_comb begin
        hold_cnt_n = '0;
        if (keep) begin
            hold_cnt_n = (hold_cnt == '1) ? hold_cnt : hold_cnt + CW'(1);
        end
    end
`else
    assign expired = 1'b0;

    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    // ------------------------------------------------------------------
    // State register: FSM state, pointer and all registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values. Blocking here would make Dout see the new sel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            last      <= 2'd3;
            gnt       <= 4'b0000;
            sel       <= 2'b00;
            Dout      <= '0;
            bus_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_n;
            last      <= last_n;
            gnt       <= gnt_n;
            sel       <= sel_n;
            Dout      <= dout_n;
            bus_valid <= valid_n;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt_n;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign win  = rr_pick(req, last);
    assign keep = (state == BUSY) && req[last] && !expired;

    // NOTE: every output of this block is given a default first. Without the
    // defaults, a path that skips an assignment would infer a latch.
    always_comb begin
        state_n = state;
        last_n  = last;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_n = BUSY;
                    last_n  = win;
                end
            end
            BUSY: begin
                // While BUSY, last is the owner. Releasing with other
                // requests pending hands off on this same edge.
                if (!keep) begin
                    if (|req) begin
                        last_n = win;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        unique case (sel)
            2'd0:    din_sel = Din0;
            2'd1:    din_sel = Din1;
            2'd2:    din_sel = Din2;
            default: din_sel = Din3;
        endcase
    end

    always_comb begin
        gnt_n   = 4'b0000;
        sel_n   = sel;
        valid_n = (state == BUSY);
        // Dout follows the pre-edge sel, so the data lags gnt by one cycle.
        dout_n  = valid_n ? din_sel : '0;
        if (state_n == BUSY) begin
            gnt_n = 4'b0001 << last_n;
            sel_n = last_n;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ============================================================================
// tb_bus_arbiter_rr
//
// This bench uses directed vectors with hand-computed expectations for
// bus_arbiter_rr. It covers reset, a single requester, an asynchronous reset
// in the middle of a tenure, and full four-way contention. It also checks
// either the tenure timeout (ARB_TIMEOUT_EN defined) or unbounded holding
// (ARB_TIMEOUT_EN undefined). Inputs change 1 time unit after each rising
// edge, and outputs are sampled at that same point.
// ============================================================================
module tb_bus_arbiter_rr;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  req;
    logic [15:0] Din0, Din1, Din2, Din3;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [15:0] Dout;
    logic        bus_valid;

    int checks   = 0;
    int failures = 0;

    bus_arbiter_rr #(
        .WIDTH    (16),
        .MAX_HOLD (8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req),
        .Din0      (Din0),
        .Din1      (Din1),
        .Din2      (Din2),
        .Din3      (Din3),
        .gnt       (gnt),
        .sel       (sel),
        .Dout      (Dout),
        .bus_valid (bus_valid)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Full-contention table. Row k gives the req value presented before edge
    // e(k+1), and the gnt, Dout and bus_valid values expected after that edge.
    logic [3:0]  ct_req   [10] = '{4'hF, 4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF};
    logic [3:0]  ct_gnt   [10] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1};
    logic [15:0] ct_dout  [10] = '{16'h0000, 16'h1111, 16'h1111, 16'h2222, 16'h2222,
                                   16'h3333, 16'h3333, 16'h4444, 16'h4444, 16'h1111};
    logic        ct_valid [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        Reset = 1'b1;
        req   = 4'b0000;
        Din0  = 16'h1111;
        Din1  = 16'h2222;
        Din2  = 16'h3333;
        Din3  = 16'h4444;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_gnt",   gnt,       4'b0000);
        check("rst_sel",   sel,       2'b00);
        check("rst_dout",  Dout,      16'h0000);
        check("rst_valid", bus_valid, 1'b0);
        Reset = 1'b0;

        // ---------------- single requester ----------------
        req = 4'b0100;
        tick();                                   // edge A: grant
        check("single_a_gnt",   gnt,       4'b0100);
        check("single_a_sel",   sel,       2'b10);
        check("single_a_valid", bus_valid, 1'b0);
        tick();                                   // edge B
        check("single_b_gnt",   gnt,       4'b0100);
        check("single_b_valid", bus_valid, 1'b1);
        check("single_b_dout",  Dout,      16'h3333);
        tick();                                   // edge C
        check("single_c_gnt",   gnt,       4'b0100);
        check("single_c_dout",  Dout,      16'h3333);
        req = 4'b0000;
        tick();                                   // edge D: release
        check("single_d_gnt",   gnt,       4'b0000);
        check("single_d_valid", bus_valid, 1'b1);
        check("single_d_dout",  Dout,      16'h3333);
        tick();                                   // edge E: idle
        check("single_e_valid", bus_valid, 1'b0);
        check("single_e_dout",  Dout,      16'h0000);
        check("single_e_sel",   sel,       2'b10);

        // ---------------- reset mid-tenure ----------------
        req = 4'b0100;
        tick();
        tick();
        check("midrst_pre_gnt",  gnt,  4'b0100);
        check("midrst_pre_dout", Dout, 16'h3333);
        #3 Reset = 1'b1;                          // between edges
        #1;
        check("midrst_gnt",   gnt,       4'b0000);
        check("midrst_sel",   sel,       2'b00);
        check("midrst_dout",  Dout,      16'h0000);
        check("midrst_valid", bus_valid, 1'b0);
        tick();
        Reset = 1'b0;

        // ---------------- full contention from reset ----------------
        for (int k = 0; k < 10; k++) begin
            req = ct_req[k];
            tick();
            check($sformatf("contend_gnt_%0d", k),   gnt,       ct_gnt[k]);
            check($sformatf("contend_dout_%0d", k),  Dout,      ct_dout[k]);
            check($sformatf("contend_valid_%0d", k), bus_valid, ct_valid[k]);
        end
        req = 4'b0000;
        tick();
        tick();
        check("contend_idle_gnt", gnt, 4'b0000);

        // Return to the reset pointer (last = 3) before the hold tests.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // ---------------- timeout, two requesters ----------------
        req = 4'b0011;
        for (int k = 1; k <= 40; k++) begin
            tick();
            check($sformatf("timeout_gnt_%0d", k), gnt,
                  ((((k - 1) / 8) % 2) == 0) ? 4'b0001 : 4'b0010);
        end
        // ---------------- timeout, lone requester ----------------
        req = 4'b1000;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("lone_gnt_%0d", k),   gnt,       4'b1000);
            check($sformatf("lone_valid_%0d", k), bus_valid, 1'b1);
        end
`else
        // ---------------- no timeout: owner keeps the bus ----------------
        req = 4'b0011;
        for (int k = 1; k <= 50; k++) begin
            tick();
            check($sformatf("notimeout_gnt_%0d", k), gnt, 4'b0001);
        end
        check("notimeout_dout", Dout, 16'h1111);
`endif

        req = 4'b0000;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
